// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage access unit: RV32I load/store funct3 codes
// and the access FSM state encoding.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// Combinational lane logic: byte enables, store-data replication, load lane
// selection with sign/zero extension, and illegal-access detection.
module load_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        illegal_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        addr_ok;
    logic        load_ok;
    logic        store_ok;

    assign byte_lane = load_word_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

    assign load_ok  = funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    assign store_ok = funct3_i inside {F3_SB, F3_SH, F3_SW};

    // Size is funct3[1:0] for both loads and stores, so one decode serves both.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = store_data_i;
        addr_ok = 1'b1;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
                addr_ok = ~addr_lo_i[0];
            end
            2'b10: begin
                be_o    = 4'b1111;
                addr_ok = (addr_lo_i == 2'b00);
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

    always_comb begin
        load_data_o = load_word_i;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   load_data_o = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  load_data_o = {24'd0, byte_lane};
            F3_LHU:  load_data_o = {16'd0, half_lane};
            default: load_data_o = load_word_i;
        endcase
    end

    assign illegal_o = (is_load_i  && !load_ok)
                    || (is_store_i && !store_ok)
                    || ((is_load_i || is_store_i) && !addr_ok);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access controller: runs one load/store per EX/MEM op
// over a req/gnt/rvalid bus and stalls the pipeline until it completes.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ex_result_mem_i,
    input  logic [31:0]       reg2_data_mem_i,
    input  logic [2:0]        funct3_mem_i,
    input  logic              mem_read_mem_i,
    input  logic              mem_write_mem_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_err_i,
    output logic              stall_o,
    output logic [31:0]       mem_rdata_o,
    output logic              misalign_o,
    output logic              access_fault_o
);

    state_t      state_q, state_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        misalign_q, misalign_d;
    logic        access_fault_q, access_fault_d;

    logic        mem_op;
    logic        req;
    logic        illegal;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;

    assign mem_op = mem_read_mem_i | mem_write_mem_i;

    load_store_align u_align (
        .addr_lo_i    (ex_result_mem_i[1:0]),
        .funct3_i     (funct3_mem_i),
        .is_load_i    (mem_read_mem_i),
        .is_store_i   (mem_write_mem_i),
        .store_data_i (reg2_data_mem_i),
        .load_word_i  (dmem_rdata_i),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_data_o  (load_data),
        .illegal_o    (illegal)
    );

    always_comb begin
        state_d        = state_q;
        mem_rdata_d    = mem_rdata_q;
        misalign_d     = 1'b0;
        access_fault_d = 1'b0;
        req            = 1'b0;
        stall_o        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (illegal) begin
                        misalign_d = 1'b1;
                    end else begin
                        req     = 1'b1;
                        stall_o = 1'b1;
                        state_d = dmem_gnt_i ? ST_WAIT : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req     = 1'b1;
                stall_o = 1'b1;
                if (dmem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    if (mem_read_mem_i) begin
                        mem_rdata_d = load_data;
                    end
                    access_fault_d = dmem_err_i;
                    state_d        = ST_DONE;
                end
            end
            // DONE releases the stall for one cycle; the EX/MEM op still shown
            // here is the one just completed, so it is not re-evaluated.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mem_rdata_q    <= 32'd0;
            misalign_q     <= 1'b0;
            access_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_rdata_q    <= mem_rdata_d;
            misalign_q     <= misalign_d;
            access_fault_q <= access_fault_d;
        end
    end

    assign dmem_req_o     = req;
    assign dmem_we_o      = req & mem_write_mem_i;
    assign dmem_addr_o    = req ? {ex_result_mem_i[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be_o      = req ? be : 4'b0000;
    assign dmem_wdata_o   = req ? wdata : 32'd0;
    assign mem_rdata_o    = mem_rdata_q;
    assign misalign_o     = misalign_q;
    assign access_fault_o = access_fault_q;

endmodule
